// File: rtl/acc_store_buffer_pkg.sv
// Shared definitions for the accumulator store buffer.
//   DATA_W_DEF / ADDR_W_DEF / DEPTH_DEF : default widths and buffer depth
//   st_entry_t                          : one pending store {addr, data}
//   drain_state_t                       : drain FSM states
package acc_store_buffer_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 5;
  localparam int DEPTH_DEF  = 2;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } st_entry_t;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } drain_state_t;

endpackage

// File: rtl/acc_store_fifo.sv
// Store buffer storage: entry arrays, read/write pointers, occupancy count
// and the combinational forwarding search.
//   i_push/i_push_addr/i_push_data : enqueue request (ignored when full)
//   i_pop                          : retire the head entry
//   i_rd_addr                      : address searched for forwarding
//   o_ready / o_empty              : registered count<DEPTH / count==0
//   o_count                        : current occupancy
//   o_head_* / o_next_*            : oldest entry and the one behind it
//   o_fwd_hit / o_fwd_data         : youngest matching pending store
module acc_store_fifo
  import acc_store_buffer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [ADDR_W-1:0]        i_push_addr,
  input  logic [DATA_W-1:0]        i_push_data,
  input  logic                     i_pop,
  input  logic [ADDR_W-1:0]        i_rd_addr,
  output logic                     o_ready,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic [ADDR_W-1:0]        o_head_addr,
  output logic [DATA_W-1:0]        o_head_data,
  output logic [ADDR_W-1:0]        o_next_addr,
  output logic [DATA_W-1:0]        o_next_data,
  output logic                     o_fwd_hit,
  output logic [DATA_W-1:0]        o_fwd_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] r_addr_mem [DEPTH];
  logic [DATA_W-1:0] r_data_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_ready;
  logic              r_empty;

  logic              w_push;
  logic [CNT_W-1:0]  w_count_nxt;
  logic [PTR_W-1:0]  w_next_ptr;
  logic [PTR_W-1:0]  w_idx;
  logic              w_fwd_hit;
  logic [DATA_W-1:0] w_fwd_data;

  // A strobe while full is dropped here; the caller flags the overflow.
  assign w_push     = i_push & r_ready;
  assign w_next_ptr = r_rd_ptr + PTR_W'(1);

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !i_pop) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (!w_push && i_pop) begin
      w_count_nxt = r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ready  <= 1'b1;
      r_empty  <= 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        r_addr_mem[i] <= '0;
        r_data_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_addr_mem[r_wr_ptr] <= i_push_addr;
        r_data_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr             <= r_wr_ptr + PTR_W'(1);
      end
      if (i_pop) begin
        r_rd_ptr <= w_next_ptr;
      end
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt < CNT_W'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  // Walk from oldest to youngest so the last match (youngest) wins.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    w_idx      = r_rd_ptr;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = r_rd_ptr + PTR_W'(k);
      if ((CNT_W'(k) < r_count) && (r_addr_mem[w_idx] == i_rd_addr)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = r_data_mem[w_idx];
      end
    end
  end

  assign o_ready     = r_ready;
  assign o_empty     = r_empty;
  assign o_count     = r_count;
  assign o_head_addr = r_addr_mem[r_rd_ptr];
  assign o_head_data = r_data_mem[r_rd_ptr];
  assign o_next_addr = r_addr_mem[w_next_ptr];
  assign o_next_data = r_data_mem[w_next_ptr];
  assign o_fwd_hit   = w_fwd_hit;
  assign o_fwd_data  = w_fwd_data;

endmodule

// File: rtl/acc_store_buffer.sv
// Accumulator store buffer: queues {st_addr, accumulator} on each store
// strobe and drains the queue to data memory over a req/ack handshake,
// while forwarding pending store data to concurrent reads.
//   accumulator/st_addr/sig_acc_to_mem : store capture
//   store_ready/buf_empty/store_overflow : buffer status (overflow sticky)
//   mem_wr_req/addr/data, mem_wr_ack   : memory write handshake
//   rd_addr, fwd_hit/fwd_data          : load forwarding
//
// state | meaning
// IDLE  | no write in flight; start one as soon as the buffer holds an entry
// REQ   | write request held with stable addr/data until the memory acks
module acc_store_buffer
  import acc_store_buffer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] accumulator,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic              sig_acc_to_mem,
  output logic              store_ready,
  output logic              buf_empty,
  output logic              store_overflow,
  output logic              mem_wr_req,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic              mem_wr_ack,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  drain_state_t      r_state;
  drain_state_t      w_state_nxt;
  logic              r_req;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_ovf;

  logic              w_req_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [DATA_W-1:0] w_data_nxt;
  logic              w_pop;
  logic              w_ready;
  logic              w_empty;
  logic [CNT_W-1:0]  w_count;
  logic [ADDR_W-1:0] w_head_addr;
  logic [DATA_W-1:0] w_head_data;
  logic [ADDR_W-1:0] w_next_addr;
  logic [DATA_W-1:0] w_next_data;

  acc_store_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (sig_acc_to_mem),
    .i_push_addr (st_addr),
    .i_push_data (accumulator),
    .i_pop       (w_pop),
    .i_rd_addr   (rd_addr),
    .o_ready     (w_ready),
    .o_empty     (w_empty),
    .o_count     (w_count),
    .o_head_addr (w_head_addr),
    .o_head_data (w_head_data),
    .o_next_addr (w_next_addr),
    .o_next_data (w_next_data),
    .o_fwd_hit   (fwd_hit),
    .o_fwd_data  (fwd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= w_req_nxt;
      r_addr  <= w_addr_nxt;
      r_data  <= w_data_nxt;
      r_ovf   <= r_ovf | (sig_acc_to_mem & ~w_ready);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_req;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_count != '0) begin
          w_addr_nxt  = w_head_addr;
          w_data_nxt  = w_head_data;
          w_req_nxt   = 1'b1;
          w_state_nxt = REQ;
        end
      end
      REQ: begin
        if (mem_wr_ack) begin
          w_pop = 1'b1;
          // The entry behind the head is already stored, so chain it
          // straight onto the bus for a back-to-back write.
          if (w_count > CNT_W'(1)) begin
            w_addr_nxt = w_next_addr;
            w_data_nxt = w_next_data;
          end else begin
            w_req_nxt   = 1'b0;
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_req_nxt   = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign store_ready    = w_ready;
  assign buf_empty      = w_empty;
  assign store_overflow = r_ovf;
  assign mem_wr_req     = r_req;
  assign mem_wr_addr    = r_addr;
  assign mem_wr_data    = r_data;

endmodule

// File: tb/tb_acc_store_buffer.sv
// Self-checking bench for acc_store_buffer: directed scenarios followed by
// randomized traffic, checked against a queue-based reference model.
module tb_acc_store_buffer;
  import acc_store_buffer_pkg::*;

  localparam int DW    = 8;
  localparam int AW    = 5;
  localparam int DEPTH = 2;

  logic          clk;
  logic          rst;
  logic [DW-1:0] accumulator;
  logic [AW-1:0] st_addr;
  logic          sig_acc_to_mem;
  logic          store_ready;
  logic          buf_empty;
  logic          store_overflow;
  logic          mem_wr_req;
  logic [AW-1:0] mem_wr_addr;
  logic [DW-1:0] mem_wr_data;
  logic          mem_wr_ack;
  logic [AW-1:0] rd_addr;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;

  acc_store_buffer #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .accumulator    (accumulator),
    .st_addr        (st_addr),
    .sig_acc_to_mem (sig_acc_to_mem),
    .store_ready    (store_ready),
    .buf_empty      (buf_empty),
    .store_overflow (store_overflow),
    .mem_wr_req     (mem_wr_req),
    .mem_wr_addr    (mem_wr_addr),
    .mem_wr_data    (mem_wr_data),
    .mem_wr_ack     (mem_wr_ack),
    .rd_addr        (rd_addr),
    .fwd_hit        (fwd_hit),
    .fwd_data       (fwd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: pending stores in program order, head = oldest.
  st_entry_t pend[$];
  bit        m_ovf    = 1'b0;
  bit        started  = 1'b0;
  bit        p_req    = 1'b0;
  bit        p_ack    = 1'b0;
  bit        p_rst    = 1'b0;
  int        p_size   = 0;
  int        n_writes = 0;

  // Monitor: all inputs/outputs are stable at the falling edge.
  always @(negedge clk) begin
    int        sz;
    int        pre;
    bit        exp_req;
    bit        m_hit;
    logic [DW-1:0] m_fd;
    if (started) begin
      sz = pend.size();
      chk("store_ready", store_ready, (sz < DEPTH));
      chk("buf_empty", buf_empty, (sz == 0));
      chk("store_overflow", store_overflow, m_ovf);
      if (p_rst)             exp_req = 1'b0;
      else if (p_req && !p_ack) exp_req = 1'b1;
      else if (p_req && p_ack)  exp_req = (p_size > 1);
      else                   exp_req = (p_size > 0);
      chk("mem_wr_req", mem_wr_req, exp_req);
      if (p_rst) begin
        chk("rst_wr_addr", mem_wr_addr, '0);
        chk("rst_wr_data", mem_wr_data, '0);
      end
      if (mem_wr_req && sz > 0) begin
        chk("wr_addr", mem_wr_addr, pend[0].addr);
        chk("wr_data", mem_wr_data, pend[0].data);
      end
      m_hit = 1'b0;
      m_fd  = '0;
      for (int i = 0; i < sz; i++) begin
        if (pend[i].addr == rd_addr) begin
          m_hit = 1'b1;
          m_fd  = pend[i].data;
        end
      end
      chk("fwd_hit", fwd_hit, m_hit);
      chk("fwd_data", fwd_data, m_fd);
    end
    if (rst) begin
      pend.delete();
      m_ovf   = 1'b0;
      started = 1'b1;
      p_size  = 0;
    end else if (started) begin
      pre = pend.size();
      if (mem_wr_req && mem_wr_ack && pre > 0) begin
        void'(pend.pop_front());
        n_writes++;
      end
      if (sig_acc_to_mem) begin
        if (pre < DEPTH) pend.push_back(st_entry_t'{addr: st_addr, data: accumulator});
        else             m_ovf = 1'b1;
      end
      p_size = pre;
    end
    p_req = mem_wr_req;
    p_ack = mem_wr_ack;
    p_rst = rst;
  end

  task automatic drv(input logic r, input logic s, input logic [DW-1:0] a,
                     input logic [AW-1:0] ad, input logic k, input logic [AW-1:0] ra);
    @(posedge clk);
    #2;
    rst            = r;
    sig_acc_to_mem = s;
    accumulator    = a;
    st_addr        = ad;
    mem_wr_ack     = k;
    rd_addr        = ra;
  endtask

  task automatic idle(input logic k);
    drv(1'b0, 1'b0, 8'h00, 5'h00, k, 5'h00);
  endtask

  initial begin
    int w0;
    logic [DW-1:0] ra_d;
    rst = 1'b1; sig_acc_to_mem = 1'b0; accumulator = '0; st_addr = '0;
    mem_wr_ack = 1'b0; rd_addr = '0;
    drv(1'b1, 1'b0, 8'h00, 5'h00, 1'b0, 5'h00);
    drv(1'b1, 1'b0, 8'h00, 5'h00, 1'b0, 5'h00);
    idle(1'b0);
    @(negedge clk);
    chk("reset_ready", store_ready, 1'b1);
    chk("reset_empty", buf_empty, 1'b1);
    chk("reset_ovf", store_overflow, 1'b0);
    chk("reset_req", mem_wr_req, 1'b0);

    // Single store, zero-wait memory.
    drv(1'b0, 1'b1, 8'h5A, 5'h03, 1'b0, 5'h00);
    idle(1'b0);
    idle(1'b1);
    @(negedge clk);
    chk("t1_req", mem_wr_req, 1'b1);
    chk("t1_addr", mem_wr_addr, 5'h03);
    chk("t1_data", mem_wr_data, 8'h5A);
    idle(1'b0);
    @(negedge clk);
    chk("t1_req_done", mem_wr_req, 1'b0);
    chk("t1_empty", buf_empty, 1'b1);

    // Back-to-back drain with wait states.
    drv(1'b0, 1'b1, 8'h11, 5'h01, 1'b0, 5'h00);
    drv(1'b0, 1'b1, 8'h22, 5'h02, 1'b0, 5'h00);
    for (int i = 0; i < 3; i++) begin
      idle(1'b0);
      @(negedge clk);
      chk("t2_hold_req", mem_wr_req, 1'b1);
      chk("t2_hold_addr", mem_wr_addr, 5'h01);
      chk("t2_hold_data", mem_wr_data, 8'h11);
    end
    idle(1'b1);
    idle(1'b1);
    @(negedge clk);
    chk("t2_b2b_req", mem_wr_req, 1'b1);
    chk("t2_b2b_addr", mem_wr_addr, 5'h02);
    chk("t2_b2b_data", mem_wr_data, 8'h22);
    idle(1'b0);
    @(negedge clk);
    chk("t2_idle_req", mem_wr_req, 1'b0);

    // Overflow with the memory stalled.
    drv(1'b0, 1'b1, 8'hA1, 5'h08, 1'b0, 5'h00);
    drv(1'b0, 1'b1, 8'hA2, 5'h09, 1'b0, 5'h00);
    drv(1'b0, 1'b1, 8'hA3, 5'h0A, 1'b0, 5'h00);
    @(negedge clk);
    chk("t3_full_ready", store_ready, 1'b0);
    chk("t3_ovf_before", store_overflow, 1'b0);
    idle(1'b0);
    w0 = n_writes;
    @(negedge clk);
    chk("t3_ovf", store_overflow, 1'b1);
    chk("t3_fwd_dropped", 32'(fwd_hit), 32'(0));
    repeat (4) idle(1'b1);
    idle(1'b0);
    idle(1'b0);
    chk("t3_writes", n_writes - w0, 2);
    chk("t3_ovf_sticky", store_overflow, 1'b1);

    // Forwarding, youngest match wins.
    drv(1'b0, 1'b1, 8'h33, 5'h04, 1'b0, 5'h00);
    drv(1'b0, 1'b1, 8'h44, 5'h04, 1'b0, 5'h00);
    drv(1'b0, 1'b0, 8'h00, 5'h00, 1'b0, 5'h04);
    @(negedge clk);
    chk("t4_hit", fwd_hit, 1'b1);
    chk("t4_data", fwd_data, 8'h44);
    drv(1'b0, 1'b0, 8'h00, 5'h00, 1'b0, 5'h05);
    @(negedge clk);
    chk("t4_miss_hit", fwd_hit, 1'b0);
    chk("t4_miss_data", fwd_data, 8'h00);

    // Reset while a write is outstanding with two entries.
    drv(1'b1, 1'b0, 8'h00, 5'h00, 1'b0, 5'h00);
    idle(1'b0);
    @(negedge clk);
    chk("t5_req", mem_wr_req, 1'b0);
    chk("t5_empty", buf_empty, 1'b1);
    chk("t5_ovf", store_overflow, 1'b0);
    repeat (3) idle(1'b1);
    @(negedge clk);
    chk("t5_no_req", mem_wr_req, 1'b0);

    // Enqueue coincident with the ack of the only entry.
    drv(1'b0, 1'b1, 8'h55, 5'h06, 1'b0, 5'h00);
    idle(1'b0);
    drv(1'b0, 1'b1, 8'h77, 5'h0C, 1'b1, 5'h00);
    idle(1'b0);
    @(negedge clk);
    chk("t6_count1_empty", buf_empty, 1'b0);
    chk("t6_count1_ready", store_ready, 1'b1);
    idle(1'b0);
    @(negedge clk);
    chk("t6_req", mem_wr_req, 1'b1);
    chk("t6_addr", mem_wr_addr, 5'h0C);
    chk("t6_data", mem_wr_data, 8'h77);
    idle(1'b1);
    idle(1'b0);
    @(negedge clk);
    chk("t6_empty", buf_empty, 1'b1);

    // Randomized traffic; the monitor checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      ra_d = 8'($urandom);
      drv(($urandom_range(0, 299) == 0), 1'($urandom_range(0, 1)), ra_d,
          5'($urandom_range(0, 3)), ($urandom_range(0, 9) < 4),
          5'($urandom_range(0, 4)));
    end
    repeat (6) idle(1'b1);
    @(negedge clk);
    chk("final_empty", buf_empty, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
